// File: rtl/cb_config_chain_ctrl.sv
// rtl/cb_config_chain_ctrl.sv - connection-box config loader: shadow shift chain, atomic commit, readback, daisy-chain out
module cb_config_chain_ctrl #(
  parameter  int CELLS  = 104,
  parameter  int CELL_W = 2,
  localparam int LEN    = CELLS * CELL_W,
  localparam int CNT_W  = $clog2(LEN + 2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             prgm_b,
  input  logic             cb_prgm_b,
  input  logic             bit_in,
  input  logic             commit,
  input  logic             capture,
  output logic             bit_out,
  output logic [LEN-1:0]   cfg_active,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             cfg_valid,
  output logic             cfg_err
);

  localparam logic [CNT_W-1:0] CNT_LEN = CNT_W'(LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LEN + 1);

  logic [LEN-1:0]   chain_q, chain_d;
  logic [LEN-1:0]   cfg_active_q, cfg_active_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             bit_out_q, bit_out_d;
  logic             cfg_valid_q, cfg_valid_d;
  logic             cfg_err_q, cfg_err_d;
  logic             shift_en;

  assign shift_en = !prgm_b && cb_prgm_b;

  always_comb begin
    chain_d      = chain_q;
    cfg_active_d = cfg_active_q;
    bit_cnt_d    = bit_cnt_q;
    bit_out_d    = bit_out_q;
    cfg_valid_d  = cfg_valid_q;
    cfg_err_d    = cfg_err_q;
    if (shift_en) begin
      chain_d   = {chain_q[LEN-2:0], bit_in};
      bit_out_d = chain_q[LEN-1];
      // Count saturates at LEN+1 so an overrun stays distinguishable from an exact load.
      if (bit_cnt_q != CNT_MAX) begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
      if (commit) begin
        cfg_err_d = 1'b1;
      end
    end else if (commit) begin
      if (bit_cnt_q == CNT_LEN) begin
        cfg_active_d = chain_q;
        cfg_valid_d  = 1'b1;
        cfg_err_d    = 1'b0;
        bit_cnt_d    = '0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else if (capture) begin
      chain_d   = cfg_active_q;
      bit_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      chain_q      <= '0;
      cfg_active_q <= '0;
      bit_cnt_q    <= '0;
      bit_out_q    <= 1'b0;
      cfg_valid_q  <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      chain_q      <= chain_d;
      cfg_active_q <= cfg_active_d;
      bit_cnt_q    <= bit_cnt_d;
      bit_out_q    <= bit_out_d;
      cfg_valid_q  <= cfg_valid_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign bit_out    = bit_out_q;
  assign cfg_active = cfg_active_q;
  assign bit_cnt    = bit_cnt_q;
  assign cfg_valid  = cfg_valid_q;
  assign cfg_err    = cfg_err_q;

endmodule
